// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult
//   Sequential radix-4 (modified Booth) multiplier with start/done handshake.
//   An operation is accepted when i_start is high in IDLE. The multiplier then
//   retires one Booth digit per clock in CALC, and pulses o_done for one cycle
//   in DONE. The product stays on o_product until the next accepted start.
//
//   Parameters
//     WIDTH      operand width in bits; must be even and >= 4
//
//   Ports
//     clk        rising-edge clock
//     n_rst      asynchronous reset, active low
//     i_start    request, sampled only in IDLE
//     i_signed   1: two's-complement operands, 0: unsigned (sampled with i_start)
//     i_mcand    multiplicand (sampled with i_start)
//     i_mplier   multiplier (sampled with i_start)
//     o_busy     high while in CALC
//     o_done     one-cycle pulse; o_product is valid
//     o_product  2*WIDTH-bit result, held from o_done until the next start
//
//   Build option
//     BOOTH_EARLY_TERM_EN  when defined, CALC finishes as soon as every
//                          remaining Booth digit is zero. The remaining shift
//                          is applied in that cycle. Latency drops to
//                          2..N+1 clocks and the result is unchanged.

module booth_r4_seq_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
  end

  localparam int unsigned PW = 2*WIDTH + 4;
  localparam int unsigned CW = $clog2(WIDTH/2 + 1);
  localparam logic [CW-1:0]      CNT_SIGNED   = CW'(WIDTH/2 - 1);
  localparam logic [CW-1:0]      CNT_UNSIGNED = CW'(WIDTH/2);
  localparam logic [WIDTH+1:0]   ONE          = {{(WIDTH+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH+1:0]     mcand_q, mcand_d;
  logic [WIDTH+1:0]     acc_q, acc_d;
  logic [WIDTH+1:0]     q_q, q_d;
  logic                 g_q, g_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
`ifdef BOOTH_EARLY_TERM_EN
  logic                 ext_q, ext_d;
  logic                 rest_ext;
`endif

  logic                 ext_in;
  logic                 last;
  logic [WIDTH+1:0]     addend;
  logic [WIDTH+1:0]     acc_sum;
  logic [PW-1:0]        pre;
  logic [PW-1:0]        post;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      g_q     <= 1'b0;
      sgn_q   <= 1'b0;
      prod_q  <= '0;
`ifdef BOOTH_EARLY_TERM_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      g_q     <= g_d;
      sgn_q   <= sgn_d;
      prod_q  <= prod_d;
`ifdef BOOTH_EARLY_TERM_EN
      ext_q   <= ext_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    g_d     = g_q;
    sgn_d   = sgn_q;
    prod_d  = prod_q;
    last    = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
    ext_d    = ext_q;
    rest_ext = 1'b1;
`endif

    ext_in = i_signed & i_mplier[WIDTH-1];

    // Booth digit from the triplet {q[1], q[0], guard}.
    case ({q_q[1:0], g_q})
      3'b001, 3'b010: addend = mcand_q;
      3'b011:         addend = mcand_q << 1;
      3'b100:         addend = ~(mcand_q << 1) + ONE;
      3'b101, 3'b110: addend = ~mcand_q + ONE;
      default:        addend = '0;
    endcase

    acc_sum = acc_q + addend;
    pre     = {acc_sum, q_q};
    post    = $signed(pre) >>> 2;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CALC;
          sgn_d   = i_signed;
          mcand_d = i_signed ? {{2{i_mcand[WIDTH-1]}}, i_mcand} : {2'b00, i_mcand};
          acc_d   = '0;
          q_d     = {ext_in, ext_in, i_mplier};
          g_d     = 1'b0;
          cnt_d   = i_signed ? CNT_SIGNED : CNT_UNSIGNED;
`ifdef BOOTH_EARLY_TERM_EN
          ext_d   = ext_in;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        last  = (cnt_q == '0);
`ifdef BOOTH_EARLY_TERM_EN
        // After this step, the unretired bits are q[2*cnt+1:2] plus the new
        // guard q[1]. If they all equal the extension bit, every remaining
        // digit is zero and one combined shift finishes the operation.
        for (int unsigned i = 1; i <= WIDTH + 1; i++) begin
          if ((i <= 2*32'(cnt_q) + 1) && (q_q[i] != ext_q)) begin
            rest_ext = 1'b0;
          end
        end
        if ((cnt_q != '0) && rest_ext) begin
          post = $signed(pre) >>> (2*32'(cnt_q) + 2);
          last = 1'b1;
        end
`endif
        acc_d = post[PW-1:WIDTH+2];
        q_d   = post[WIDTH+1:0];
        g_d   = q_q[1];
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          // Signed runs use only WIDTH/2 steps. The two extension bits
          // therefore remain at the bottom, and the product sits 2 bits up.
          prod_d  = sgn_q ? post[2*WIDTH+1:2] : post[2*WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy    = (state_q == CALC);
  assign o_done    = (state_q == DONE);
  assign o_product = prod_q;

endmodule
